watch_set_ctrl: RTL and testbench

- Button-driven time-setting controller for the watch timekeeping counter.
- Snapshots the running date/time into shadow registers and steps the user through year, month, day, hour, minute and second fields, with wrap and calendar-correct day limits.
- Commits the edited value to the timekeeper as a one-cycle set_time pulse with a 52-bit packed bin_time.
- Sits between the debounced push-button logic and the timekeeper; also drives the edit-field indication and blink for the display.

---
 rtl/watch_set_ctrl.sv | 157 +++++++++++++++
 tb/tb_watch_set_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/watch_set_ctrl.sv
// Button-driven time-setting controller: snapshots live time into shadow
// registers, edits each field with wrap and calendar limits, then commits.
module watch_set_ctrl #(
    parameter int TIMEOUT_S = 10,
    parameter int YEAR_MAX  = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1sec,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [51:0] cur_time,
    output logic        set_time,
    output logic [51:0] bin_time,
    output logic        edit_active,
    output logic [2:0]  edit_field,
    output logic        blink
);
    // Edit-state encodings double as the edit_field code.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        E_YEAR  = 3'd1,
        E_MONTH = 3'd2,
        E_DAY   = 3'd3,
        E_HOUR  = 3'd4,
        E_MIN   = 3'd5,
        E_SEC   = 3'd6,
        COMMIT  = 3'd7
    } state_t;

    localparam logic [11:0] YEAR_TOP = 12'(YEAR_MAX);
    localparam logic [5:0]  TMO      = 6'(TIMEOUT_S);

    state_t      r_state, w_next;
    logic [11:0] r_year;
    logic [7:0]  r_month, r_day, r_hour, r_min, r_sec;
    logic [5:0]  r_tmo;
    logic        r_set_time, r_edit_active, r_blink;
    logic [2:0]  r_edit_field;

    logic        w_any_btn, w_inc, w_dec, w_ud;
    logic        w_in_edit, w_next_edit, w_timed_out, w_leap;
    logic [7:0]  w_max_date;

    assign w_any_btn   = btn_mode | btn_inc | btn_dec;
    assign w_inc       = btn_inc & ~btn_dec & ~btn_mode;
    assign w_dec       = btn_dec & ~btn_inc & ~btn_mode;
    assign w_ud        = w_inc | w_dec;
    assign w_in_edit   = (r_state != IDLE) && (r_state != COMMIT);
    assign w_next_edit = (w_next != IDLE) && (w_next != COMMIT);
    assign w_timed_out = w_in_edit && (r_tmo >= TMO);

    assign w_leap = ((r_year[1:0] == 2'd0) && ((r_year % 12'd100) != 12'd0))
                  || ((r_year % 12'd400) == 12'd0);

    function automatic logic [7:0] wrap8(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi, input logic up);
        if (up) return (v >= hi) ? lo : v + 8'd1;
        else    return (v <= lo) ? hi : v - 8'd1;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_max_date = 8'd31;
        case (r_month)
            8'd2:                      w_max_date = 8'd28 + {7'd0, w_leap};
            8'd4, 8'd6, 8'd9, 8'd11:   w_max_date = 8'd30;
            default:                   w_max_date = 8'd31;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (btn_mode) w_next = E_YEAR;
            COMMIT:  w_next = IDLE;
            default: begin
                if (w_timed_out) begin
                    w_next = IDLE;
                end else if (btn_mode) begin
                    case (r_state)
                        E_YEAR:  w_next = E_MONTH;
                        E_MONTH: w_next = E_DAY;
                        E_DAY:   w_next = E_HOUR;
                        E_HOUR:  w_next = E_MIN;
                        E_MIN:   w_next = E_SEC;
                        E_SEC:   w_next = COMMIT;
                        default: w_next = IDLE;
                    endcase
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_set_time    <= 1'b0;
            r_edit_active <= 1'b0;
            r_edit_field  <= 3'd0;
            r_blink       <= 1'b0;
            r_tmo         <= 6'd0;
        end else begin
            r_state       <= w_next;
            r_set_time    <= (w_next == COMMIT);
            r_edit_active <= w_next_edit;
            r_edit_field  <= w_next_edit ? w_next : IDLE;

            if (!w_next_edit)  r_blink <= 1'b0;
            else if (w_any_btn) r_blink <= 1'b1;
            else if (clk1sec)   r_blink <= ~r_blink;

            if (!w_next_edit || !w_in_edit || w_any_btn) r_tmo <= 6'd0;
            else if (clk1sec)                            r_tmo <= r_tmo + 6'd1;
        end
    end

    // Shadow registers; the day clamp on leaving year/month keeps the date legal.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_year  <= 12'd2021;
            r_month <= 8'd5;
            r_day   <= 8'd30;
            r_hour  <= 8'd0;
            r_min   <= 8'd0;
            r_sec   <= 8'd0;
        end else if (r_state == IDLE) begin
            if (btn_mode) {r_year, r_month, r_day, r_hour, r_min, r_sec} <= cur_time;
        end else if (w_in_edit && !w_timed_out) begin
            case (r_state)
                E_YEAR: begin
                    if (btn_mode && (r_day > w_max_date)) r_day <= w_max_date;
                    else if (w_inc) r_year <= (r_year >= YEAR_TOP) ? 12'd1 : r_year + 12'd1;
                    else if (w_dec) r_year <= (r_year <= 12'd1) ? YEAR_TOP : r_year - 12'd1;
                end
                E_MONTH: begin
                    if (btn_mode && (r_day > w_max_date)) r_day <= w_max_date;
                    else if (w_ud) r_month <= wrap8(r_month, 8'd1, 8'd12, w_inc);
                end
                E_DAY:   if (w_ud) r_day  <= wrap8(r_day, 8'd1, w_max_date, w_inc);
                E_HOUR:  if (w_ud) r_hour <= wrap8(r_hour, 8'd0, 8'd23, w_inc);
                E_MIN:   if (w_ud) r_min  <= wrap8(r_min, 8'd0, 8'd59, w_inc);
                E_SEC:   if (w_ud) r_sec  <= wrap8(r_sec, 8'd0, 8'd59, w_inc);
                default: ;
            endcase
        end
    end

    assign set_time    = r_set_time;
    assign bin_time    = {r_year, r_month, r_day, r_hour, r_min, r_sec};
    assign edit_active = r_edit_active;
    assign edit_field  = r_edit_field;
    assign blink       = r_blink;
endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl; committed values flow through a scoreboard
// queue checked whenever set_time pulses.
module tb_watch_set_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        clk1sec, btn_mode, btn_inc, btn_dec;
    logic [51:0] cur_time;
    logic        set_time, edit_active, blink;
    logic [51:0] bin_time;
    logic [2:0]  edit_field;

    int n_checks = 0;
    int n_errors = 0;
    logic [51:0] sb[$];

    watch_set_ctrl #(.TIMEOUT_S(10), .YEAR_MAX(4095)) dut (
        .clk(clk), .rst(rst), .clk1sec(clk1sec),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_time(cur_time), .set_time(set_time), .bin_time(bin_time),
        .edit_active(edit_active), .edit_field(edit_field), .blink(blink)
    );

    always #5 clk = ~clk;

    function automatic logic [51:0] pack(input int y, input int mo, input int d,
                                         input int h, input int mi, input int s);
        return {12'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    endfunction

    task automatic check(input string tag, input logic [51:0] obs, input logic [51:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: inputs driven at a falling edge, outputs read at the next one.
    task automatic step(input logic m, input logic i, input logic d, input logic s);
        btn_mode = m; btn_inc = i; btn_dec = d; clk1sec = s;
        @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; clk1sec = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && set_time === 1'b1) begin
            check("set_time_expected", 52'(sb.size() != 0), 52'd1);
            if (sb.size() != 0) check("commit_bin_time", bin_time, sb.pop_front());
        end
    end

    task automatic commit_flow(input int year, input int exp_day);
        cur_time = pack(year, 1, 31, 10, 20, 30);
        step(1, 0, 0, 0);
        check("enter_field", 52'(edit_field), 52'd1);
        check("snapshot", bin_time, pack(year, 1, 31, 10, 20, 30));
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        check("month_inc", bin_time, pack(year, 2, 31, 10, 20, 30));
        step(1, 0, 0, 0);
        check("day_clamp", bin_time, pack(year, 2, exp_day, 10, 20, 30));
        check("day_field", 52'(edit_field), 52'd3);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("sec_field", 52'(edit_field), 52'd6);
        sb.push_back(pack(year, 2, exp_day, 10, 20, 30));
        step(1, 0, 0, 0);
        check("commit_pulse", 52'(set_time), 52'd1);
        check("commit_field", 52'(edit_field), 52'd0);
        check("commit_active", 52'(edit_active), 52'd0);
        step(0, 0, 0, 0);
        check("commit_one_cycle", 52'(set_time), 52'd0);
    endtask

    initial begin
        rst = 1'b0;
        {clk1sec, btn_mode, btn_inc, btn_dec} = 4'b0;
        cur_time = pack(1111, 11, 11, 11, 11, 11);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
        check("rst_set_time", 52'(set_time), 52'd0);
        check("rst_field", 52'(edit_field), 52'd0);
        check("rst_active", 52'(edit_active), 52'd0);
        check("rst_blink", 52'(blink), 52'd0);
        check("rst_shadow", bin_time, pack(2021, 5, 30, 0, 0, 0));

        commit_flow(2024, 29);
        commit_flow(2100, 28);
        commit_flow(2000, 29);

        // Field wrap boundaries.
        cur_time = pack(4095, 6, 1, 23, 0, 45);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        check("year_wrap_up", bin_time, pack(1, 6, 1, 23, 0, 45));
        step(0, 0, 1, 0);
        check("year_wrap_down", bin_time, pack(4095, 6, 1, 23, 0, 45));
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        check("day_wrap_down", bin_time, pack(4095, 6, 30, 23, 0, 45));
        step(0, 1, 0, 0);
        check("day_wrap_up", bin_time, pack(4095, 6, 1, 23, 0, 45));
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        check("hour_wrap_up", bin_time, pack(4095, 6, 1, 0, 0, 45));
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        check("min_wrap_down", bin_time, pack(4095, 6, 1, 0, 59, 45));
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        check("inc_dec_ignored", bin_time, pack(4095, 6, 1, 0, 59, 45));
        step(0, 1, 0, 0);
        check("sec_inc", bin_time, pack(4095, 6, 1, 0, 59, 46));
        sb.push_back(pack(4095, 6, 1, 0, 59, 46));
        step(1, 0, 0, 0);
        check("wrap_commit_pulse", 52'(set_time), 52'd1);
        step(0, 0, 0, 0);

        // Mode beats inc, then a button restarts the inactivity count.
        cur_time = pack(2023, 3, 10, 1, 2, 3);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        check("mode_priority_field", 52'(edit_field), 52'd3);
        check("mode_priority_month", bin_time, pack(2023, 3, 10, 1, 2, 3));
        for (int k = 0; k < 9; k++) step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        check("restart_day_inc", bin_time, pack(2023, 3, 11, 1, 2, 3));
        for (int k = 0; k < 9; k++) step(0, 0, 0, 1);
        check("restart_still_edit", 52'(edit_field), 52'd3);
        step(0, 0, 0, 1);
        check("tmo_reached_active", 52'(edit_active), 52'd1);
        step(0, 0, 0, 0);
        check("tmo_idle_field", 52'(edit_field), 52'd0);
        check("tmo_idle_active", 52'(edit_active), 52'd0);
        check("tmo_no_commit", 52'(set_time), 52'd0);
        check("tmo_shadow_kept", bin_time, pack(2023, 3, 11, 1, 2, 3));
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        check("idle_inc_dec_ignored", bin_time, pack(2023, 3, 11, 1, 2, 3));
        check("idle_stays", 52'(edit_field), 52'd0);

        // Fresh entry, blink toggling, and a plain timeout.
        cur_time = pack(1999, 12, 25, 8, 9, 10);
        step(1, 0, 0, 0);
        check("blink_on_btn", 52'(blink), 52'd1);
        step(0, 0, 0, 1);
        check("blink_toggle_1", 52'(blink), 52'd0);
        step(0, 0, 0, 1);
        check("blink_toggle_2", 52'(blink), 52'd1);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 1);
        check("tmo10_still_active", 52'(edit_active), 52'd1);
        step(0, 0, 0, 0);
        check("tmo10_idle", 52'(edit_field), 52'd0);
        check("tmo10_blink_off", 52'(blink), 52'd0);
        check("tmo10_shadow", bin_time, pack(1999, 12, 25, 8, 9, 10));

        // Reset in the middle of an edit abandons it.
        cur_time = pack(1500, 7, 4, 12, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_field", 52'(edit_field), 52'd0);
        check("midrst_set_time", 52'(set_time), 52'd0);
        check("midrst_shadow", bin_time, pack(2021, 5, 30, 0, 0, 0));
        rst = 1'b1;
        step(0, 0, 0, 0);
        check("midrst_idle", 52'(edit_active), 52'd0);

        check("sb_empty", 52'(sb.size()), 52'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
